// File: rtl/xor_reduce_pkg.sv
// rtl/xor_reduce_pkg.sv - shared limits and stage control type for the xor_reduce_stream pipeline
package xor_reduce_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;
    localparam int WIDTH_MIN  = 2;
    localparam int WIDTH_MAX  = 256;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctl_t;

endpackage

// File: rtl/xor_reduce_stage.sv
// rtl/xor_reduce_stage.sv - one registered stage folding N_IN partial parity bits into N_IN/2
module xor_reduce_stage
    import xor_reduce_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [N_IN-1:0]   in_part,
    output logic              out_valid,
    output logic              out_last,
    output logic [N_IN/2-1:0] out_part
);

    localparam int N_OUT = N_IN / 2;

    stage_ctl_t       ctl_q;
    logic [N_OUT-1:0] part_q;
    logic [N_OUT-1:0] fold;

    always_comb begin
        fold = '0;
        for (int i = 0; i < N_OUT; i++) begin
            fold[i] = in_part[2*i] ^ in_part[2*i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q  <= '0;
            part_q <= '0;
        end else if (adv) begin
            ctl_q.valid <= in_valid;
            ctl_q.last  <= in_last;
            part_q      <= fold;
        end
    end

    assign out_valid = ctl_q.valid;
    assign out_last  = ctl_q.last;
    assign out_part  = part_q;

endmodule

// File: rtl/xor_reduce_stream.sv
// rtl/xor_reduce_stream.sv - pipelined word parity stream; XOR_REDUCE_STREAM_PKT_EN adds running packet parity
module xor_reduce_stream
    import xor_reduce_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_last,
    output logic             out_pkt_parity
);

    localparam int P = 1 << (STAGES - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_check
        $error("xor_reduce_stream: WIDTH or STAGES outside legal range");
    end

    logic               adv;
    logic [P-1:0]       fold0;
    logic [P-1:0]       part0_q;
    stage_ctl_t         ctl0_q;
    logic [STAGES-1:0]  vld;
    logic [STAGES-1:0]  lst;
    // Partials of all stages packed back to back: stage k occupies P>>k bits
    // starting at 2P - (2P>>k); the final parity bit sits at index 2P-2.
    logic [2*P-2:0]     parts;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        fold0 = '0;
        for (int j = 0; j < WIDTH; j++) begin
            fold0[j % P] = fold0[j % P] ^ in_data[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl0_q  <= '0;
            part0_q <= '0;
        end else if (adv) begin
            ctl0_q.valid <= in_valid;
            ctl0_q.last  <= in_last;
            part0_q      <= fold0;
        end
    end

    assign vld[0]       = ctl0_q.valid;
    assign lst[0]       = ctl0_q.last;
    assign parts[P-1:0] = part0_q;

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        localparam int N_IN  = P >> (k - 1);
        localparam int OFF_I = 2*P - ((2*P) >> (k - 1));
        localparam int OFF_O = 2*P - ((2*P) >> k);

        xor_reduce_stage #(
            .N_IN (N_IN)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_valid  (vld[k-1]),
            .in_last   (lst[k-1]),
            .in_part   (parts[OFF_I +: N_IN]),
            .out_valid (vld[k]),
            .out_last  (lst[k]),
            .out_part  (parts[OFF_O +: N_IN/2])
        );
    end

    assign out_valid  = vld[STAGES-1];
    assign out_last   = lst[STAGES-1];
    assign out_parity = parts[2*P-2];

`ifdef XOR_REDUCE_STREAM_PKT_EN
    logic acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (out_valid && out_ready) begin
            acc <= out_last ? 1'b0 : out_pkt_parity;
        end
    end

    assign out_pkt_parity = acc ^ out_parity;
`else
    assign out_pkt_parity = 1'b0;
`endif

endmodule

// File: tb/tb_xor_reduce_stream.sv
// tb/tb_xor_reduce_stream.sv - self-checking bench for xor_reduce_stream
module tb_xor_reduce_stream;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, out_parity, out_last, out_pkt_parity;

    always #5 clk = ~clk;

    xor_reduce_stream #(.WIDTH(W), .STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_parity     (out_parity),
        .out_last       (out_last),
        .out_pkt_parity (out_pkt_parity)
    );

    // Sweep instances: index s-1 is WIDTH=5, index s+3 is WIDTH=256, s = STAGES.
    logic       sw_go = 1'b0;
    logic [7:0] sw_rdy, sw_valid, sw_par, sw_last, sw_pkt;

    for (genvar s = 1; s <= 4; s++) begin : g_sw
        xor_reduce_stream #(.WIDTH(5), .STAGES(s)) u_w5 (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_go), .in_ready(sw_rdy[s-1]),
            .in_data({5{1'b1}}), .in_last(1'b0), .out_valid(sw_valid[s-1]),
            .out_ready(1'b1), .out_parity(sw_par[s-1]), .out_last(sw_last[s-1]),
            .out_pkt_parity(sw_pkt[s-1])
        );
        xor_reduce_stream #(.WIDTH(256), .STAGES(s)) u_w256 (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_go), .in_ready(sw_rdy[s+3]),
            .in_data({256{1'b1}}), .in_last(1'b0), .out_valid(sw_valid[s+3]),
            .out_ready(1'b1), .out_parity(sw_par[s+3]), .out_last(sw_last[s+3]),
            .out_pkt_parity(sw_pkt[s+3])
        );
    end

    typedef struct packed {
        logic par;
        logic last;
        logic pkt;
    } exp_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         par;
    } vec_t;

    exp_t     sb[$];
    exp_t     e_push, e_pop;
    logic     got_pkt[$];
    logic     drv_exp = 1'b0;
    logic     m_acc = 1'b0;
    logic     stall_q = 1'b0;
    logic [2:0] stall_snap = '0;
    bit       rand_mode = 1'b0;
    int       n_checks = 0;
    int       n_fail = 0;
    int       n_deliv = 0;
    int       n_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_acc   = 1'b0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_hold", {out_valid, out_parity, out_last, out_pkt_parity},
                      {1'b1, stall_snap});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e_pop = sb.pop_front();
                    check("out_parity", out_parity, e_pop.par);
                    check("out_last", out_last, e_pop.last);
                    check("out_pkt_parity", out_pkt_parity, e_pop.pkt);
                end
                n_deliv++;
                got_pkt.push_back(out_pkt_parity);
            end
            stall_q    = out_valid && !out_ready;
            stall_snap = {out_parity, out_last, out_pkt_parity};
            if (in_valid && in_ready) begin
                e_push.par  = drv_exp;
                e_push.last = in_last;
`ifdef XOR_REDUCE_STREAM_PKT_EN
                e_push.pkt  = m_acc ^ drv_exp;
                m_acc       = in_last ? 1'b0 : e_push.pkt;
`else
                e_push.pkt  = 1'b0;
`endif
                sb.push_back(e_push);
                n_accept++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send(input logic [W-1:0] d, input logic l, input logic e);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        drv_exp  = e;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                return;
            end
            t++;
            if (t > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_done", (t < 100), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[10];
        logic pkt_exp[4];
        int   lat[8];
        logic sw_p[8];
        logic sw_k[8];
        int   base_d, base_a;
        logic [W-1:0] r;

        vt[0] = '{16'h0001, 1'b0, 1'b1};
        vt[1] = '{16'h0003, 1'b0, 1'b0};
        vt[2] = '{16'hFFFF, 1'b0, 1'b0};
        vt[3] = '{16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h7FFF, 1'b1, 1'b1};
        vt[5] = '{16'hA5A5, 1'b0, 1'b0};
        vt[6] = '{16'h0000, 1'b0, 1'b0};
        vt[7] = '{16'h1234, 1'b1, 1'b1};
        vt[8] = '{16'h00FF, 1'b0, 1'b0};
        vt[9] = '{16'hFFFE, 1'b1, 1'b1};

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_parity", out_parity, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_pkt", out_pkt_parity, 1'b0);
        check("rst_sweep_ready", sw_rdy, 8'hFF);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Two-word latency sequence at STAGES=2
        in_valid = 1'b1; in_data = 16'h0001; in_last = 1'b0; drv_exp = 1'b1;
        @(posedge clk); #1;
        check("lat_c1_valid", out_valid, 1'b0);
        in_data = 16'h0003; drv_exp = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_c2_valid", out_valid, 1'b1);
        check("lat_c2_parity", out_parity, 1'b1);
        @(posedge clk); #1;
        check("lat_c3_valid", out_valid, 1'b1);
        check("lat_c3_parity", out_parity, 1'b0);
        @(posedge clk); #1;
        check("lat_c4_valid", out_valid, 1'b0);

        // Table vectors, back to back
        for (int i = 0; i < 10; i++) send(vt[i].data, vt[i].last, vt[i].par);
        drain();

        // Packet parity sequence
        got_pkt.delete();
        send(16'h0001, 1'b0, 1'b1);
        send(16'h0003, 1'b0, 1'b0);
        send(16'h0007, 1'b1, 1'b1);
        send(16'h0001, 1'b1, 1'b1);
        drain();
`ifdef XOR_REDUCE_STREAM_PKT_EN
        pkt_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
        pkt_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check("pkt_seq_count", got_pkt.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_pkt.size()) check("pkt_seq_value", got_pkt[i], pkt_exp[i]);
        end

        // STAGES / WIDTH sweep with all-ones words
        for (int i = 0; i < 8; i++) begin lat[i] = 0; sw_p[i] = 1'b0; sw_k[i] = 1'b0; end
        sw_go = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) sw_go = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (sw_valid[i] && lat[i] == 0) begin
                    lat[i]  = c;
                    sw_p[i] = sw_par[i];
                    sw_k[i] = sw_pkt[i];
                    check("sweep_last", sw_last[i], 1'b0);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            check("sweep_latency", lat[i], (i % 4) + 1);
            check("sweep_parity", sw_p[i], (i < 4) ? 1'b1 : 1'b0);
`ifdef XOR_REDUCE_STREAM_PKT_EN
            check("sweep_pkt", sw_k[i], (i < 4) ? 1'b1 : 1'b0);
`else
            check("sweep_pkt", sw_k[i], 1'b0);
`endif
        end

        // Full pipeline with downstream stalled, then a single-cycle release
        out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
        for (int k = 0; k < 10; k++) begin
            r = W'($urandom);
            in_data = r; drv_exp = ^r;
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk); #1;
        end
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        base_d = n_deliv; base_a = n_accept;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("one_cycle_deliveries", n_deliv - base_d, 32'd1);
        check("one_cycle_accepts", n_accept - base_a, 32'd1);
        check("refull_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // 100 random words against random backpressure
        base_d = n_deliv;
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = W'($urandom);
            send(r, ($urandom_range(0, 7) == 0), ^r);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        rand_mode = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
        check("random_count", n_deliv - base_d, 32'd100);

        // Asynchronous reset mid-packet with two words in flight
        send(16'h0003, 1'b1, 1'b0);
        send(16'h0001, 1'b0, 1'b1);
        drain();
        out_ready = 1'b0;
        send(16'h0003, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b1);
        in_valid = 1'b0;
        check("inflight_out_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_pkt", out_pkt_parity, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        got_pkt.delete();
        base_d = n_deliv;
        send(16'h0001, 1'b1, 1'b1);
        drain();
        check("post_rst_count", n_deliv - base_d, 32'd1);
`ifdef XOR_REDUCE_STREAM_PKT_EN
        if (got_pkt.size() > 0) check("post_rst_pkt", got_pkt[0], 1'b1);
`else
        if (got_pkt.size() > 0) check("post_rst_pkt", got_pkt[0], 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
